// File: rtl/e203_exu_wbck_arb.sv
// Write-back arbiter for the single register-file write port.
// Merges the ALU result path with a FIFO-buffered long-pipe path; a starvation
// counter forces the FIFO head through after STARVE_MAX lost arbitration cycles.
module e203_exu_wbck_arb #(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned RFIDX_W     = 5,
   parameter int unsigned LFIFO_DEPTH = 2,
   parameter int unsigned STARVE_MAX  = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               alu_wbck_i_valid,
   output logic               alu_wbck_i_ready,
   input  logic [RFIDX_W-1:0] alu_wbck_i_rdidx,
   input  logic [XLEN-1:0]    alu_wbck_i_wdat,
   input  logic               longp_wbck_i_valid,
   output logic               longp_wbck_i_ready,
   input  logic [RFIDX_W-1:0] longp_wbck_i_rdidx,
   input  logic [XLEN-1:0]    longp_wbck_i_wdat,
   output logic               rf_wbck_o_ena,
   output logic [RFIDX_W-1:0] rf_wbck_o_rdidx,
   output logic [XLEN-1:0]    rf_wbck_o_wdat,
   output logic               longp_pend_o
);

   localparam int unsigned AW = $clog2(LFIFO_DEPTH);
   localparam int unsigned SW = $clog2(STARVE_MAX + 1);
   localparam logic [AW:0]    PtrOne    = {{AW{1'b0}}, 1'b1};
   localparam logic [SW-1:0]  StarveMax = SW'(STARVE_MAX);
   localparam logic [SW-1:0]  StarveOne = {{(SW-1){1'b0}}, 1'b1};

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [AW:0]         wr_ptr_q, wr_ptr_d;
   logic [AW:0]         rd_ptr_q, rd_ptr_d;
   logic [SW-1:0]       starve_cnt_q, starve_cnt_d;
   logic [RFIDX_W-1:0]  idx_mem [LFIFO_DEPTH];
   logic [XLEN-1:0]     dat_mem [LFIFO_DEPTH];

   logic empty, full, push, force_pop, fifo_grant, alu_grant;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   assign force_pop = (starve_cnt_q == StarveMax) && !empty;
   // Nothing is granted while reset is held, so discarded entries are never written.
   assign fifo_grant = !rst && !empty && (force_pop || !alu_wbck_i_valid);
   assign alu_grant  = !rst && !fifo_grant && alu_wbck_i_valid;
   assign push       = longp_wbck_i_valid && !full;

   assign alu_wbck_i_ready   = !fifo_grant;
   assign longp_wbck_i_ready = !full;
   assign longp_pend_o       = !empty;

   // Next-state for pointers and the starvation counter.
   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      starve_cnt_d = starve_cnt_q;
      if (push) wr_ptr_d = wr_ptr_q + PtrOne;
      if (fifo_grant) rd_ptr_d = rd_ptr_q + PtrOne;
      if (empty || fifo_grant) begin
         starve_cnt_d = '0;
      end else if (alu_grant && (starve_cnt_q != StarveMax)) begin
         starve_cnt_d = starve_cnt_q + StarveOne;
      end
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         starve_cnt_q <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         starve_cnt_q <= starve_cnt_d;
      end
   end

   // FIFO storage; contents need no reset since the pointers gate visibility.
   always_ff @(posedge clk) begin
      if (push) begin
         idx_mem[wr_ptr_q[AW-1:0]] <= longp_wbck_i_rdidx;
         dat_mem[wr_ptr_q[AW-1:0]] <= longp_wbck_i_wdat;
      end
   end

   // Write-port mux; x0 targets complete the handshake but suppress the write.
   always_comb begin
      rf_wbck_o_rdidx = '0;
      rf_wbck_o_wdat  = '0;
      if (fifo_grant) begin
         rf_wbck_o_rdidx = idx_mem[rd_ptr_q[AW-1:0]];
         rf_wbck_o_wdat  = dat_mem[rd_ptr_q[AW-1:0]];
      end else if (alu_grant) begin
         rf_wbck_o_rdidx = alu_wbck_i_rdidx;
         rf_wbck_o_wdat  = alu_wbck_i_wdat;
      end
      rf_wbck_o_ena = (fifo_grant || alu_grant) && (rf_wbck_o_rdidx != '0);
   end

endmodule

// File: tb/tb_e203_exu_wbck_arb.sv
// Self-checking bench: queue-based reference model, directed scenarios, random traffic.
module tb_e203_exu_wbck_arb;
   localparam int unsigned XLEN  = 32;
   localparam int unsigned RW    = 5;
   localparam int unsigned DEPTH = 2;
   localparam int unsigned SMAX  = 4;

   typedef struct packed {
      logic [RW-1:0]   idx;
      logic [XLEN-1:0] dat;
   } ent_t;

   logic            clk = 1'b0;
   logic            rst;
   logic            alu_v, alu_rdy, lp_v, lp_rdy, ena, pend;
   logic [RW-1:0]   alu_idx, lp_idx, rf_idx;
   logic [XLEN-1:0] alu_dat, lp_dat, rf_dat;

   always #5 clk = ~clk;

   e203_exu_wbck_arb #(
      .XLEN(XLEN), .RFIDX_W(RW), .LFIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .alu_wbck_i_valid   (alu_v),
      .alu_wbck_i_ready   (alu_rdy),
      .alu_wbck_i_rdidx   (alu_idx),
      .alu_wbck_i_wdat    (alu_dat),
      .longp_wbck_i_valid (lp_v),
      .longp_wbck_i_ready (lp_rdy),
      .longp_wbck_i_rdidx (lp_idx),
      .longp_wbck_i_wdat  (lp_dat),
      .rf_wbck_o_ena      (ena),
      .rf_wbck_o_rdidx    (rf_idx),
      .rf_wbck_o_wdat     (rf_dat),
      .longp_pend_o       (pend)
   );

   // Reference model state: buffered long-pipe results in arrival order.
   ent_t q[$];
   int   starve;
   int   n_tests, n_fail;
   logic m_fifo_g, m_alu_g, m_alu_hs, m_lp_hs;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Called with clk low and inputs applied: compare outputs with the model.
   task automatic settle();
      logic [RW-1:0]   e_idx;
      logic [XLEN-1:0] e_dat;
      #1;
      m_fifo_g = !rst && (q.size() > 0) && ((starve == SMAX) || !alu_v);
      m_alu_g  = !rst && !m_fifo_g && alu_v;
      e_idx = '0;
      e_dat = '0;
      if (m_fifo_g) begin
         e_idx = q[0].idx;
         e_dat = q[0].dat;
      end else if (m_alu_g) begin
         e_idx = alu_idx;
         e_dat = alu_dat;
      end
      m_alu_hs = alu_v && !m_fifo_g;
      m_lp_hs  = lp_v && (q.size() < DEPTH);
      check_eq("alu_ready", 64'(alu_rdy), 64'(!m_fifo_g));
      check_eq("longp_ready", 64'(lp_rdy), 64'(q.size() < DEPTH));
      check_eq("pend", 64'(pend), 64'(q.size() > 0));
      check_eq("ena", 64'(ena), 64'((m_fifo_g || m_alu_g) && (e_idx != 0)));
      check_eq("rdidx", 64'(rf_idx), 64'(e_idx));
      check_eq("wdat", 64'(rf_dat), 64'(e_dat));
   endtask

   // Update the model for the coming edge, then move to the next falling edge.
   task automatic advance();
      int was_empty;
      was_empty = (q.size() == 0);
      if (rst) begin
         q.delete();
         starve = 0;
      end else begin
         if (m_lp_hs) q.push_back('{idx: lp_idx, dat: lp_dat});
         if (m_fifo_g) void'(q.pop_front());
         if (was_empty || m_fifo_g) starve = 0;
         else if (m_alu_g && starve < SMAX) starve++;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic step();
      settle();
      advance();
   endtask

   task automatic drive(input logic av, input logic [RW-1:0] ai, input logic [XLEN-1:0] ad,
                        input logic lv, input logic [RW-1:0] li, input logic [XLEN-1:0] ld);
      alu_v = av; alu_idx = ai; alu_dat = ad;
      lp_v  = lv; lp_idx  = li; lp_dat  = ld;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      starve  = 0;
      rst     = 1'b1;
      drive(1'b0, '0, '0, 1'b0, '0, '0);
      @(negedge clk);

      // Reset then idle.
      step();
      step();
      rst = 1'b0;
      repeat (3) step();

      // ALU only, including an x0 target.
      drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
      settle();
      check_eq("alu_only_ena", 64'(ena), 64'd1);
      check_eq("alu_only_data", 64'(rf_dat), 64'hDEADBEEF);
      advance();
      drive(1'b1, 5'd0, 32'h12345678, 1'b0, '0, '0);
      settle();
      check_eq("alu_x0_ena", 64'(ena), 64'd0);
      check_eq("alu_x0_ready", 64'(alu_rdy), 64'd1);
      advance();

      // Fill the FIFO while the ALU keeps winning, then drain in order.
      drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd7, 32'h11);
      step();
      drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd8, 32'h22);
      step();
      drive(1'b1, 5'd1, 32'h1, 1'b0, '0, '0);
      settle();
      check_eq("fill_full_ready", 64'(lp_rdy), 64'd0);
      advance();
      drive(1'b0, '0, '0, 1'b0, '0, '0);
      settle();
      check_eq("drain_first", 64'({rf_idx, rf_dat}), 64'({5'd7, 32'h11}));
      advance();
      settle();
      check_eq("drain_second", 64'({rf_idx, rf_dat}), 64'({5'd8, 32'h22}));
      advance();
      settle();
      check_eq("drain_pend_low", 64'(pend), 64'd0);
      advance();

      // Starvation: one entry, continuous ALU traffic.
      drive(1'b1, 5'd9, 32'h99, 1'b1, 5'd3, 32'h55);
      step();
      drive(1'b1, 5'd9, 32'h99, 1'b0, '0, '0);
      for (int i = 0; i < SMAX; i++) begin
         settle();
         check_eq("starve_alu_wins", 64'(alu_rdy), 64'd1);
         advance();
      end
      settle();
      check_eq("starve_forced", 64'({ena, alu_rdy, rf_idx, rf_dat}), 64'({2'b10, 5'd3, 32'h55}));
      advance();
      settle();
      check_eq("starve_alu_resumes", 64'({alu_rdy, rf_idx}), 64'({1'b1, 5'd9}));
      advance();

      // Full FIFO with a held push and an idle ALU: six entries stream in order.
      drive(1'b1, 5'd2, 32'h2, 1'b0, '0, '0);
      for (int n = 0; n < 6; ) begin
         if (!lp_v) begin
            lp_v   = 1'b1;
            lp_idx = RW'($urandom_range(1, 31));
            lp_dat = $urandom;
         end
         if (n >= 2) alu_v = 1'b0;
         settle();
         if (m_lp_hs) n++;
         advance();
         if (m_lp_hs) lp_v = 1'b0;
      end
      drive(1'b0, '0, '0, 1'b0, '0, '0);
      repeat (4) step();

      // Reset mid-operation with two buffered entries.
      drive(1'b1, 5'd4, 32'h4, 1'b1, 5'd10, 32'hA0);
      step();
      drive(1'b1, 5'd4, 32'h4, 1'b1, 5'd11, 32'hB0);
      step();
      drive(1'b0, '0, '0, 1'b0, '0, '0);
      rst = 1'b1;
      settle();
      check_eq("rst_mid_no_write", 64'(ena), 64'd0);
      advance();
      rst = 1'b0;
      settle();
      check_eq("rst_mid_pend", 64'(pend), 64'd0);
      advance();
      repeat (3) step();

      // Random traffic; producers hold valid and payload until accepted.
      drive(1'b0, '0, '0, 1'b0, '0, '0);
      for (int c = 0; c < 400; c++) begin
         rst = ($urandom_range(0, 59) == 0);
         if (!alu_v && $urandom_range(0, 3) != 0) begin
            alu_v   = 1'b1;
            alu_idx = ($urandom_range(0, 7) == 0) ? '0 : RW'($urandom);
            alu_dat = $urandom;
         end
         if (!lp_v && $urandom_range(0, 2) == 0) begin
            lp_v   = 1'b1;
            lp_idx = ($urandom_range(0, 7) == 0) ? '0 : RW'($urandom);
            lp_dat = $urandom;
         end
         settle();
         advance();
         if (m_alu_hs) alu_v = 1'b0;
         if (m_lp_hs) lp_v = 1'b0;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
